// File: rtl/pmem_arbiter.sv
// Purpose : shares one physical-memory port between the I-cache (read-only) and the D-cache (read/write).
// Latency : request seen at edge N drives the pmem strobe from cycle N+1; resp is returned combinationally with pmem_resp.
// Backpr. : requesters hold their request until resp; a loser waits, at most one transaction with DCACHE_PRIORITY=0.
//
// Ports:
//   clk, rst_n                      - clock (rising edge), asynchronous active-low reset
//   icache_pmem_*                   - I-cache line read request/address, rdata/resp back
//   dcache_pmem_*                   - D-cache line read/write request/address/wdata, rdata/resp back
//   pmem_read/write/address/wdata   - physical memory strobes, driven only from latched state
//   pmem_rdata, pmem_resp           - physical memory read line and one-cycle completion
module pmem_arbiter #(
    parameter bit DCACHE_PRIORITY = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,

    input  logic         icache_pmem_read,
    input  logic [15:0]  icache_pmem_address,
    output logic [127:0] icache_pmem_rdata,
    output logic         icache_pmem_resp,

    input  logic         dcache_pmem_read,
    input  logic         dcache_pmem_write,
    input  logic [15:0]  dcache_pmem_address,
    input  logic [127:0] dcache_pmem_wdata,
    output logic [127:0] dcache_pmem_rdata,
    output logic         dcache_pmem_resp,

    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT_I = 2'd1,
        S_GRANT_D = 2'd2
    } state_t;

    localparam logic GRANT_IS_I = 1'b0;
    localparam logic GRANT_IS_D = 1'b1;

    state_t        state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic [15:0]   addr_q, addr_d;
    logic [127:0]  wdata_q, wdata_d;
    // The latched op doubles as the pmem strobes: both are cleared whenever
    // the arbiter drops back to IDLE, so they are registered outputs.
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;

    logic          ireq;
    logic          dreq;
    logic          pick_d;

    assign ireq = icache_pmem_read;
    assign dreq = dcache_pmem_read | dcache_pmem_write;

    // Winner in IDLE: a lone requester always wins; on a tie D wins under
    // priority mode, otherwise the side that was not served last wins.
    assign pick_d = dreq & (~ireq | DCACHE_PRIORITY | (last_grant_q == GRANT_IS_I));

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rd_d         = rd_q;
        wr_d         = wr_q;

        case (state_q)
            S_IDLE: begin
                if (ireq || dreq) begin
                    if (pick_d) begin
                        state_d = S_GRANT_D;
                        addr_d  = dcache_pmem_address & 16'hFFF0;
                        wdata_d = dcache_pmem_wdata;
                        // Read and write together is a write-back.
                        wr_d    = dcache_pmem_write;
                        rd_d    = ~dcache_pmem_write;
                    end else begin
                        state_d = S_GRANT_I;
                        addr_d  = icache_pmem_address & 16'hFFF0;
                        wdata_d = '0;
                        wr_d    = 1'b0;
                        rd_d    = 1'b1;
                    end
                end
            end

            S_GRANT_I: begin
                if (pmem_resp) begin
                    last_grant_d = GRANT_IS_I;
                    // Hand straight over to a waiting D-cache; the I-cache's
                    // own request is still high this cycle and must be ignored.
                    if (dreq) begin
                        state_d = S_GRANT_D;
                        addr_d  = dcache_pmem_address & 16'hFFF0;
                        wdata_d = dcache_pmem_wdata;
                        wr_d    = dcache_pmem_write;
                        rd_d    = ~dcache_pmem_write;
                    end else begin
                        state_d = S_IDLE;
                        rd_d    = 1'b0;
                        wr_d    = 1'b0;
                    end
                end
            end

            S_GRANT_D: begin
                if (pmem_resp) begin
                    last_grant_d = GRANT_IS_D;
                    if (ireq) begin
                        state_d = S_GRANT_I;
                        addr_d  = icache_pmem_address & 16'hFFF0;
                        wdata_d = '0;
                        wr_d    = 1'b0;
                        rd_d    = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        rd_d    = 1'b0;
                        wr_d    = 1'b0;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= GRANT_IS_D;
            addr_q       <= '0;
            wdata_q      <= '0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
        end
    end

    assign pmem_read    = rd_q;
    assign pmem_write   = wr_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

    // A pmem_resp seen in IDLE (e.g. stale after a reset) is dropped here.
    assign icache_pmem_resp  = (state_q == S_GRANT_I) & pmem_resp;
    assign dcache_pmem_resp  = (state_q == S_GRANT_D) & pmem_resp;

    assign icache_pmem_rdata = pmem_rdata;
    assign dcache_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Purpose : self-checking bench for pmem_arbiter in priority and round-robin modes.
// Latency : checks strobe one cycle after request and back-to-back handover.
// Backpr. : models caches holding requests until resp and a memory answering in order.
module tb_pmem_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         icache_pmem_read;
    logic [15:0]  icache_pmem_address;
    logic         dcache_pmem_read;
    logic         dcache_pmem_write;
    logic [15:0]  dcache_pmem_address;
    logic [127:0] dcache_pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    // Priority-mode instance outputs
    logic [127:0] p_i_rdata, p_d_rdata, p_wdata;
    logic         p_i_resp, p_d_resp, p_read, p_write;
    logic [15:0]  p_address;
    // Round-robin instance outputs
    logic [127:0] r_i_rdata, r_d_rdata, r_wdata;
    logic         r_i_resp, r_d_resp, r_read, r_write;
    logic [15:0]  r_address;

    bit sel_rr = 1'b0;
    int vectors = 0;
    int miscompares = 0;

    logic [127:0] obs_i_rdata, obs_d_rdata, obs_wdata;
    logic         obs_i_resp, obs_d_resp, obs_read, obs_write;
    logic [15:0]  obs_address;

    assign obs_i_rdata = sel_rr ? r_i_rdata : p_i_rdata;
    assign obs_d_rdata = sel_rr ? r_d_rdata : p_d_rdata;
    assign obs_wdata   = sel_rr ? r_wdata   : p_wdata;
    assign obs_i_resp  = sel_rr ? r_i_resp  : p_i_resp;
    assign obs_d_resp  = sel_rr ? r_d_resp  : p_d_resp;
    assign obs_read    = sel_rr ? r_read    : p_read;
    assign obs_write   = sel_rr ? r_write   : p_write;
    assign obs_address = sel_rr ? r_address : p_address;

    pmem_arbiter #(.DCACHE_PRIORITY(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .icache_pmem_read(icache_pmem_read), .icache_pmem_address(icache_pmem_address),
        .icache_pmem_rdata(p_i_rdata), .icache_pmem_resp(p_i_resp),
        .dcache_pmem_read(dcache_pmem_read), .dcache_pmem_write(dcache_pmem_write),
        .dcache_pmem_address(dcache_pmem_address), .dcache_pmem_wdata(dcache_pmem_wdata),
        .dcache_pmem_rdata(p_d_rdata), .dcache_pmem_resp(p_d_resp),
        .pmem_read(p_read), .pmem_write(p_write), .pmem_address(p_address),
        .pmem_wdata(p_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    pmem_arbiter #(.DCACHE_PRIORITY(1'b0)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .icache_pmem_read(icache_pmem_read), .icache_pmem_address(icache_pmem_address),
        .icache_pmem_rdata(r_i_rdata), .icache_pmem_resp(r_i_resp),
        .dcache_pmem_read(dcache_pmem_read), .dcache_pmem_write(dcache_pmem_write),
        .dcache_pmem_address(dcache_pmem_address), .dcache_pmem_wdata(dcache_pmem_wdata),
        .dcache_pmem_rdata(r_d_rdata), .dcache_pmem_resp(r_d_resp),
        .pmem_read(r_read), .pmem_write(r_write), .pmem_address(r_address),
        .pmem_wdata(r_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           is_d;
        bit           wr;
        logic [15:0]  addr;
        logic [127:0] wdata;
        logic [127:0] rdata;
    } txn_t;

    txn_t exp_q[$];

    function automatic txn_t mk(input bit is_d, input bit wr, input logic [15:0] addr,
                                input logic [127:0] wdata, input logic [127:0] rdata);
        txn_t t;
        t.is_d = is_d; t.wr = wr; t.addr = addr; t.wdata = wdata; t.rdata = rdata;
        return t;
    endfunction

    task automatic do_reset();
        icache_pmem_read    = 1'b0;
        icache_pmem_address = '0;
        dcache_pmem_read    = 1'b0;
        dcache_pmem_write   = 1'b0;
        dcache_pmem_address = '0;
        dcache_pmem_wdata   = '0;
        pmem_rdata          = '0;
        pmem_resp           = 1'b0;
        rst_n               = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Memory model: waits for a grant, checks it against the scoreboard head,
    // answers with that entry's rdata and checks the routed response.
    task automatic serve_one(input bit drop, input int hold, input bit next_busy, output int lat);
        txn_t t;
        bit   found;
        found = 1'b0;
        lat   = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            lat++;
            if (obs_read || obs_write) found = 1'b1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL grant_timeout: no pmem strobe within %0d cycles", lat);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            return;
        end
        t = exp_q.pop_front();
        vectors++;
        if ({obs_read, obs_write} !== {~t.wr, t.wr}) begin
            miscompares++;
            $display("FAIL strobes: got rd/wr=%b%b want %b%b", obs_read, obs_write, ~t.wr, t.wr);
        end
        vectors++;
        if (obs_address !== t.addr) begin
            miscompares++;
            $display("FAIL address: got %h want %h", obs_address, t.addr);
        end
        if (t.wr) begin
            vectors++;
            if (obs_wdata !== t.wdata) begin
                miscompares++;
                $display("FAIL wdata: got %h want %h", obs_wdata, t.wdata);
            end
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            dcache_pmem_wdata   = ~dcache_pmem_wdata;
            dcache_pmem_address = dcache_pmem_address ^ 16'h0ff0;
            icache_pmem_address = icache_pmem_address ^ 16'h0ff0;
            @(negedge clk);
            vectors++;
            if (obs_address !== t.addr || (t.wr && obs_wdata !== t.wdata)) begin
                miscompares++;
                $display("FAIL hold_stable: got addr %h wdata %h want addr %h wdata %h",
                         obs_address, obs_wdata, t.addr, t.wdata);
            end
        end
        pmem_rdata = t.rdata;
        pmem_resp  = 1'b1;
        #1;
        vectors++;
        if ({obs_i_resp, obs_d_resp} !== {~t.is_d, t.is_d}) begin
            miscompares++;
            $display("FAIL resp_route: got i/d=%b%b want %b%b", obs_i_resp, obs_d_resp, ~t.is_d, t.is_d);
        end
        vectors++;
        if ((t.is_d ? obs_d_rdata : obs_i_rdata) !== t.rdata) begin
            miscompares++;
            $display("FAIL rdata: got %h want %h", t.is_d ? obs_d_rdata : obs_i_rdata, t.rdata);
        end
        @(posedge clk);
        #1;
        pmem_resp = 1'b0;
        if (drop) begin
            if (t.is_d) begin
                dcache_pmem_read  = 1'b0;
                dcache_pmem_write = 1'b0;
            end else begin
                icache_pmem_read = 1'b0;
            end
        end
        @(negedge clk);
        vectors++;
        if ({obs_i_resp, obs_d_resp} !== 2'b00) begin
            miscompares++;
            $display("FAIL resp_pulse: got i/d=%b%b want 00", obs_i_resp, obs_d_resp);
        end
        vectors++;
        if ((obs_read | obs_write) !== next_busy) begin
            miscompares++;
            $display("FAIL handover: got busy=%b want %b", obs_read | obs_write, next_busy);
        end
        if (next_busy && exp_q.size() > 0) begin
            vectors++;
            if (obs_address !== exp_q[0].addr) begin
                miscompares++;
                $display("FAIL handover_addr: got %h want %h", obs_address, exp_q[0].addr);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        pmem_rdata = {8{16'hBEEF}};
        #2;
        vectors++;
        if ({p_read, p_write, r_read, r_write} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_strobes: got %b want 0000", {p_read, p_write, r_read, r_write});
        end
        vectors++;
        if (p_address !== 16'h0 || p_wdata !== 128'h0) begin
            miscompares++;
            $display("FAIL reset_addr_wdata: got %h %h want 0 0", p_address, p_wdata);
        end
        vectors++;
        if ({p_i_resp, p_d_resp, r_i_resp, r_d_resp} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_resp: got %b want 0000", {p_i_resp, p_d_resp, r_i_resp, r_d_resp});
        end
        vectors++;
        if (p_i_rdata !== {8{16'hBEEF}} || p_d_rdata !== {8{16'hBEEF}}) begin
            miscompares++;
            $display("FAIL rdata_pass: got %h %h want %h", p_i_rdata, p_d_rdata, {8{16'hBEEF}});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_icache_read();
        int lat;
        icache_pmem_address = 16'h1234;
        icache_pmem_read    = 1'b1;
        exp_q.push_back(mk(1'b0, 1'b0, 16'h1230, '0, {16{8'hAA}}));
        @(negedge clk);
        vectors++;
        if ((obs_read | obs_write) !== 1'b0) begin
            miscompares++;
            $display("FAIL latency_early: got strobe %b want 0", obs_read | obs_write);
        end
        serve_one(1'b1, 0, 1'b0, lat);
        vectors++;
        if (lat != 1) begin
            miscompares++;
            $display("FAIL latency: got %0d cycles want 1", lat);
        end
    endtask

    task automatic test_dcache_write();
        int lat;
        dcache_pmem_address = 16'h4000;
        dcache_pmem_wdata   = 128'h0123456789ABCDEF0123456789ABCDEF;
        dcache_pmem_write   = 1'b1;
        exp_q.push_back(mk(1'b1, 1'b1, 16'h4000, 128'h0123456789ABCDEF0123456789ABCDEF, {16{8'h5A}}));
        serve_one(1'b1, 2, 1'b0, lat);
    endtask

    task automatic test_back_to_back();
        int lat;
        icache_pmem_address = 16'h0100;
        dcache_pmem_address = 16'h2000;
        icache_pmem_read    = 1'b1;
        dcache_pmem_read    = 1'b1;
        exp_q.push_back(mk(1'b1, 1'b0, 16'h2000, '0, {16{8'h55}}));
        exp_q.push_back(mk(1'b0, 1'b0, 16'h0100, '0, {16{8'hC3}}));
        serve_one(1'b1, 0, 1'b1, lat);
        serve_one(1'b1, 0, 1'b0, lat);
    endtask

    task automatic test_round_robin();
        int lat;
        do_reset();
        sel_rr = 1'b1;
        icache_pmem_address = 16'h0100;
        dcache_pmem_address = 16'h2000;
        icache_pmem_read    = 1'b1;
        dcache_pmem_read    = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) exp_q.push_back(mk(1'b0, 1'b0, 16'h0100, '0, {16{8'h10 + 8'(k)}}));
            else            exp_q.push_back(mk(1'b1, 1'b0, 16'h2000, '0, {16{8'h20 + 8'(k)}}));
        end
        for (int k = 0; k < 4; k++) serve_one(1'b0, 0, 1'b1, lat);
        do_reset();
        sel_rr = 1'b0;
    endtask

    task automatic test_reset_mid_grant();
        int  lat;
        bit  found;
        dcache_pmem_address = 16'h3000;
        dcache_pmem_read    = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (obs_read) found = 1'b1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL midreset_grant: got no pmem_read want 1");
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({obs_read, obs_write} !== 2'b00 || obs_address !== 16'h0) begin
            miscompares++;
            $display("FAIL async_reset: got rd/wr=%b%b addr %h want 00 0000", obs_read, obs_write, obs_address);
        end
        pmem_rdata = {16{8'h99}};
        pmem_resp  = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if ({obs_i_resp, obs_d_resp} !== 2'b00) begin
            miscompares++;
            $display("FAIL stale_resp: got i/d=%b%b want 00", obs_i_resp, obs_d_resp);
        end
        #1;
        pmem_resp = 1'b0;
        exp_q.push_back(mk(1'b1, 1'b0, 16'h3000, '0, {16{8'h77}}));
        serve_one(1'b1, 0, 1'b0, lat);
        vectors++;
        if (lat != 1) begin
            miscompares++;
            $display("FAIL regrant_latency: got %0d cycles want 1", lat);
        end
    endtask

    task automatic test_read_write_together();
        int lat;
        dcache_pmem_address = 16'h5008;
        dcache_pmem_wdata   = {4{32'hCAFEF00D}};
        dcache_pmem_read    = 1'b1;
        dcache_pmem_write   = 1'b1;
        exp_q.push_back(mk(1'b1, 1'b1, 16'h5000, {4{32'hCAFEF00D}}, {16{8'h3C}}));
        serve_one(1'b1, 0, 1'b0, lat);
    endtask

    initial begin
        do_reset();
        test_reset();
        test_icache_read();
        test_dcache_write();
        test_back_to_back();
        test_round_robin();
        test_reset_mid_grant();
        test_read_write_together();
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
